// File: rtl/axis_width_converter.sv
// AXI-Stream data-width converter: packs narrow beats (upsize), unpacks wide words (downsize),
// or registers a pass-through. Optional tuser sideband enabled by AXIS_WIDTH_CONV_TUSER_EN.
module axis_width_converter #(
  parameter int unsigned S_DATA_WIDTH = 8,
  parameter int unsigned M_DATA_WIDTH = 32,
  parameter int unsigned TUSER_WIDTH  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [S_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [S_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                        s_axis_tlast,
`ifdef AXIS_WIDTH_CONV_TUSER_EN
  input  logic [TUSER_WIDTH-1:0]      s_axis_tuser,
  output logic [TUSER_WIDTH-1:0]      m_axis_tuser,
`endif
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [M_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [M_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic                        m_axis_tlast
);

  localparam int unsigned S_KEEP = S_DATA_WIDTH / 8;
  localparam int unsigned M_KEEP = M_DATA_WIDTH / 8;
  localparam int unsigned RATIO  = (M_DATA_WIDTH > S_DATA_WIDTH) ? M_DATA_WIDTH / S_DATA_WIDTH
                                                                 : S_DATA_WIDTH / M_DATA_WIDTH;

  // Elaboration-time parameter legality
  if ((S_DATA_WIDTH == 0) || (M_DATA_WIDTH == 0) ||
      ((S_DATA_WIDTH % 8) != 0) || ((M_DATA_WIDTH % 8) != 0)) begin : g_err_bytes
    $error("axis_width_converter: data widths must be nonzero multiples of 8");
  end
  if (((M_DATA_WIDTH >= S_DATA_WIDTH) && ((M_DATA_WIDTH % S_DATA_WIDTH) != 0)) ||
      ((S_DATA_WIDTH > M_DATA_WIDTH) && ((S_DATA_WIDTH % M_DATA_WIDTH) != 0))) begin : g_err_ratio
    $error("axis_width_converter: larger width must be an integer multiple of the smaller");
  end
  if (TUSER_WIDTH == 0) begin : g_err_user
    $error("axis_width_converter: TUSER_WIDTH must be at least 1");
  end

  if (M_DATA_WIDTH > S_DATA_WIDTH) begin : g_up
    localparam int unsigned LANE_W = $clog2(RATIO);

    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [M_DATA_WIDTH-1:0] acc_data_q, acc_data_d, word_data_c, m_data_q, m_data_d;
    logic [M_KEEP-1:0]       acc_keep_q, acc_keep_d, word_keep_c, m_keep_q, m_keep_d;
    logic                    m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic                    s_ready_c, s_fire_c;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
    logic [TUSER_WIDTH-1:0]  acc_user_q, acc_user_d, word_user_c, m_user_q, m_user_d;
`endif

    assign s_ready_c = !m_valid_q || m_axis_tready;
    assign s_fire_c  = s_axis_tvalid && s_ready_c;

    // Merge the incoming beat into its lane; emit on the last lane or on tlast
    always_comb begin
      word_data_c = acc_data_q;
      word_keep_c = acc_keep_q;
      word_data_c[lane_q*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
      word_keep_c[lane_q*S_KEEP +: S_KEEP]             = s_axis_tkeep;
      lane_d     = lane_q;
      acc_data_d = acc_data_q;
      acc_keep_d = acc_keep_q;
      m_valid_d  = m_valid_q;
      m_data_d   = m_data_q;
      m_keep_d   = m_keep_q;
      m_last_d   = m_last_q;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
      word_user_c = acc_user_q | s_axis_tuser;
      acc_user_d  = acc_user_q;
      m_user_d    = m_user_q;
`endif
      if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;
      if (s_fire_c) begin
        if (s_axis_tlast || (lane_q == LANE_W'(RATIO - 1))) begin
          m_valid_d  = 1'b1;
          m_data_d   = word_data_c;
          m_keep_d   = word_keep_c;
          m_last_d   = s_axis_tlast;
          lane_d     = '0;
          acc_data_d = '0;
          acc_keep_d = '0;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
          m_user_d   = word_user_c;
          acc_user_d = '0;
`endif
        end else begin
          lane_d     = lane_q + LANE_W'(1);
          acc_data_d = word_data_c;
          acc_keep_d = word_keep_c;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
          acc_user_d = word_user_c;
`endif
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        lane_q     <= '0;
        acc_data_q <= '0;
        acc_keep_q <= '0;
        m_valid_q  <= 1'b0;
        m_data_q   <= '0;
        m_keep_q   <= '0;
        m_last_q   <= 1'b0;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
        acc_user_q <= '0;
        m_user_q   <= '0;
`endif
      end else begin
        lane_q     <= lane_d;
        acc_data_q <= acc_data_d;
        acc_keep_q <= acc_keep_d;
        m_valid_q  <= m_valid_d;
        m_data_q   <= m_data_d;
        m_keep_q   <= m_keep_d;
        m_last_q   <= m_last_d;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
        acc_user_q <= acc_user_d;
        m_user_q   <= m_user_d;
`endif
      end
    end

    assign s_axis_tready = s_ready_c;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
    assign m_axis_tuser  = m_user_q;
`endif

  end else if (S_DATA_WIDTH > M_DATA_WIDTH) begin : g_down
    localparam int unsigned SEG_W   = $clog2(RATIO);
    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_BUSY = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [SEG_W-1:0]        seg_q, seg_d, last_seg_q, last_seg_d, new_last_c;
    logic [S_DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [S_KEEP-1:0]       hold_keep_q, hold_keep_d;
    logic                    hold_last_q, hold_last_d;
    logic [M_DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [M_KEEP-1:0]       m_keep_q, m_keep_d;
    logic                    m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic                    s_ready_c, s_fire_c;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
    logic [TUSER_WIDTH-1:0]  m_user_q, m_user_d;
`endif

    assign s_ready_c = (state_q == ST_IDLE) || (m_axis_tready && (seg_q == last_seg_q));
    assign s_fire_c  = s_axis_tvalid && s_ready_c;

    // Final segment of an incoming word: highest kept segment for tlast words, else the top one
    always_comb begin
      new_last_c = SEG_W'(RATIO - 1);
      if (s_axis_tlast) begin
        new_last_c = '0;
        for (int unsigned j = 0; j < RATIO; j++) begin
          if (|s_axis_tkeep[j*M_KEEP +: M_KEEP]) new_last_c = SEG_W'(j);
        end
      end
    end

    always_comb begin
      state_d     = state_q;
      seg_d       = seg_q;
      last_seg_d  = last_seg_q;
      hold_data_d = hold_data_q;
      hold_keep_d = hold_keep_q;
      hold_last_d = hold_last_q;
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      m_keep_d    = m_keep_q;
      m_last_d    = m_last_q;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
      m_user_d    = m_user_q;
`endif
      if (s_fire_c) begin
        state_d     = ST_BUSY;
        seg_d       = '0;
        last_seg_d  = new_last_c;
        hold_data_d = s_axis_tdata;
        hold_keep_d = s_axis_tkeep;
        hold_last_d = s_axis_tlast;
        m_valid_d   = 1'b1;
        m_data_d    = s_axis_tdata[M_DATA_WIDTH-1:0];
        m_keep_d    = s_axis_tkeep[M_KEEP-1:0];
        m_last_d    = s_axis_tlast && (new_last_c == '0);
`ifdef AXIS_WIDTH_CONV_TUSER_EN
        m_user_d    = s_axis_tuser;
`endif
      end else if ((state_q == ST_BUSY) && m_axis_tready) begin
        if (seg_q == last_seg_q) begin
          state_d   = ST_IDLE;
          m_valid_d = 1'b0;
        end else begin
          seg_d    = seg_q + SEG_W'(1);
          m_data_d = hold_data_q[seg_d*M_DATA_WIDTH +: M_DATA_WIDTH];
          m_keep_d = hold_keep_q[seg_d*M_KEEP +: M_KEEP];
          m_last_d = hold_last_q && (seg_d == last_seg_q);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q     <= ST_IDLE;
        seg_q       <= '0;
        last_seg_q  <= '0;
        hold_data_q <= '0;
        hold_keep_q <= '0;
        hold_last_q <= 1'b0;
        m_valid_q   <= 1'b0;
        m_data_q    <= '0;
        m_keep_q    <= '0;
        m_last_q    <= 1'b0;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
        m_user_q    <= '0;
`endif
      end else begin
        state_q     <= state_d;
        seg_q       <= seg_d;
        last_seg_q  <= last_seg_d;
        hold_data_q <= hold_data_d;
        hold_keep_q <= hold_keep_d;
        hold_last_q <= hold_last_d;
        m_valid_q   <= m_valid_d;
        m_data_q    <= m_data_d;
        m_keep_q    <= m_keep_d;
        m_last_q    <= m_last_d;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
        m_user_q    <= m_user_d;
`endif
      end
    end

    assign s_axis_tready = s_ready_c;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
    assign m_axis_tuser  = m_user_q;
`endif

  end else begin : g_pass
    logic [M_DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [M_KEEP-1:0]       m_keep_q, m_keep_d;
    logic                    m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic                    s_ready_c;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
    logic [TUSER_WIDTH-1:0]  m_user_q, m_user_d;
`endif

    assign s_ready_c = !m_valid_q || m_axis_tready;

    // Single register slice
    always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_keep_d  = m_keep_q;
      m_last_d  = m_last_q;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
      m_user_d  = m_user_q;
`endif
      if (m_valid_q && m_axis_tready) m_valid_d = 1'b0;
      if (s_axis_tvalid && s_ready_c) begin
        m_valid_d = 1'b1;
        m_data_d  = s_axis_tdata;
        m_keep_d  = s_axis_tkeep;
        m_last_d  = s_axis_tlast;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
        m_user_d  = s_axis_tuser;
`endif
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        m_valid_q <= 1'b0;
        m_data_q  <= '0;
        m_keep_q  <= '0;
        m_last_q  <= 1'b0;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
        m_user_q  <= '0;
`endif
      end else begin
        m_valid_q <= m_valid_d;
        m_data_q  <= m_data_d;
        m_keep_q  <= m_keep_d;
        m_last_q  <= m_last_d;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
        m_user_q  <= m_user_d;
`endif
      end
    end

    assign s_axis_tready = s_ready_c;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
    assign m_axis_tuser  = m_user_q;
`endif
  end

endmodule

// File: tb/tb_axis_width_converter.sv
// Bench for axis_width_converter: an 8->32 upsizer and a 32->8 downsizer checked against
// constant expectations through per-direction scoreboards.
module tb_axis_width_converter;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic        keep;
    logic        last;
    logic        user;
    logic        emit;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_last;
    logic        exp_user;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        up_s_valid, up_s_ready, up_s_last, up_m_valid, up_m_ready, up_m_last;
  logic [7:0]  up_s_data;
  logic [0:0]  up_s_keep;
  logic [31:0] up_m_data;
  logic [3:0]  up_m_keep;
  logic        dn_s_valid, dn_s_ready, dn_s_last, dn_m_valid, dn_m_ready, dn_m_last;
  logic [31:0] dn_s_data;
  logic [3:0]  dn_s_keep;
  logic [7:0]  dn_m_data;
  logic [0:0]  dn_m_keep;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
  logic [0:0]  up_s_user, up_m_user, dn_s_user, dn_m_user;
`endif

  axis_width_converter #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(32), .TUSER_WIDTH(1)) u_up (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(up_s_valid), .s_axis_tready(up_s_ready), .s_axis_tdata(up_s_data),
    .s_axis_tkeep(up_s_keep), .s_axis_tlast(up_s_last),
`ifdef AXIS_WIDTH_CONV_TUSER_EN
    .s_axis_tuser(up_s_user), .m_axis_tuser(up_m_user),
`endif
    .m_axis_tvalid(up_m_valid), .m_axis_tready(up_m_ready), .m_axis_tdata(up_m_data),
    .m_axis_tkeep(up_m_keep), .m_axis_tlast(up_m_last)
  );

  axis_width_converter #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8), .TUSER_WIDTH(1)) u_dn (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(dn_s_valid), .s_axis_tready(dn_s_ready), .s_axis_tdata(dn_s_data),
    .s_axis_tkeep(dn_s_keep), .s_axis_tlast(dn_s_last),
`ifdef AXIS_WIDTH_CONV_TUSER_EN
    .s_axis_tuser(dn_s_user), .m_axis_tuser(dn_m_user),
`endif
    .m_axis_tvalid(dn_m_valid), .m_axis_tready(dn_m_ready), .m_axis_tdata(dn_m_data),
    .m_axis_tkeep(dn_m_keep), .m_axis_tlast(dn_m_last)
  );

  int          tests = 0;
  int          fails = 0;
  exp_t        up_q[$];
  exp_t        dn_q[$];
  vec_t        vecs[$];
  logic        up_fire, dn_fire, up_stall, dn_stall, dn_toggle;
  logic [37:0] up_saved;
  logic [13:0] dn_saved;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic exp_t mke(input logic [31:0] d, input logic [3:0] k, input logic l,
                               input logic u);
    exp_t e;
    e.data = d; e.keep = k; e.last = l; e.user = u;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [7:0] d, input logic k, input logic l, input logic u,
                               input logic em, input logic [31:0] ed, input logic [3:0] ek,
                               input logic el, input logic eu);
    vec_t v;
    v.data = d; v.keep = k; v.last = l; v.user = u; v.emit = em;
    v.exp_data = ed; v.exp_keep = ek; v.exp_last = el; v.exp_user = eu;
    return v;
  endfunction

  task automatic up_pop();
    exp_t e;
    if (up_q.size() == 0) begin
      check("up_unexpected_beat", 64'({up_m_last, up_m_keep, up_m_data}), 64'(0));
    end else begin
      e = up_q.pop_front();
      check("up_word", 64'({up_m_last, up_m_keep, up_m_data}), 64'({e.last, e.keep, e.data}));
`ifdef AXIS_WIDTH_CONV_TUSER_EN
      check("up_user", 64'(up_m_user), 64'(e.user));
`endif
    end
  endtask

  task automatic dn_pop();
    exp_t e;
    if (dn_q.size() == 0) begin
      check("dn_unexpected_beat", 64'({dn_m_last, dn_m_keep, dn_m_data}), 64'(0));
    end else begin
      e = dn_q.pop_front();
      check("dn_seg", 64'({dn_m_last, dn_m_keep, dn_m_data}), 64'({e.last, e.keep[0], e.data[7:0]}));
`ifdef AXIS_WIDTH_CONV_TUSER_EN
      check("dn_user", 64'(dn_m_user), 64'(e.user));
`endif
    end
  endtask

  // One clock: observe handshakes at the falling edge, then advance past the rising edge
  task automatic step();
    @(negedge clk);
    up_fire = up_s_valid && up_s_ready;
    dn_fire = dn_s_valid && dn_s_ready;
    if (!rst) begin
      if (up_m_valid && up_m_ready) up_pop();
      if (dn_m_valid && dn_m_ready) dn_pop();
      if (up_stall) check("up_hold", 64'({up_m_valid, up_m_last, up_m_keep, up_m_data}), 64'(up_saved));
      if (dn_stall) check("dn_hold", 64'({dn_m_valid, dn_m_last, dn_m_keep, dn_m_data}), 64'(dn_saved));
    end
    up_stall = !rst && up_m_valid && !up_m_ready;
    dn_stall = !rst && dn_m_valid && !dn_m_ready;
    up_saved = {up_m_valid, up_m_last, up_m_keep, up_m_data};
    dn_saved = {dn_m_valid, dn_m_last, dn_m_keep, dn_m_data};
    @(posedge clk);
    #1;
    if (dn_toggle) dn_m_ready = !dn_m_ready;
  endtask

  task automatic up_send(input logic [7:0] d, input logic k, input logic l, input logic u,
                         output int n);
    up_s_valid = 1'b1; up_s_data = d; up_s_keep = k; up_s_last = l;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
    up_s_user = u;
`else
    if (u) n = 0;
`endif
    n = 0;
    do begin step(); n++; end while (!up_fire && n < 50);
    if (!up_fire) check("up_send_timeout", 64'(0), 64'(1));
    up_s_valid = 1'b0;
  endtask

  task automatic dn_send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    int n;
    dn_s_valid = 1'b1; dn_s_data = d; dn_s_keep = k; dn_s_last = l;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
    dn_s_user = u;
`else
    if (u) n = 0;
`endif
    n = 0;
    do begin step(); n++; end while (!dn_fire && n < 50);
    if (!dn_fire) check("dn_send_timeout", 64'(0), 64'(1));
    dn_s_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; dn_toggle = 1'b0; up_stall = 1'b0; dn_stall = 1'b0;
    up_fire = 1'b0; dn_fire = 1'b0; up_saved = '0; dn_saved = '0;
    up_s_valid = 1'b0; up_s_data = '0; up_s_keep = '0; up_s_last = 1'b0; up_m_ready = 1'b1;
    dn_s_valid = 1'b0; dn_s_data = '0; dn_s_keep = '0; dn_s_last = 1'b0; dn_m_ready = 1'b1;
`ifdef AXIS_WIDTH_CONV_TUSER_EN
    up_s_user = '0; dn_s_user = '0;
`endif
    // Upsize vectors: {in data, keep, last, user, emits, exp data, exp keep, exp last, exp user}
    vecs.push_back(mkv(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0));
    vecs.push_back(mkv(8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0));
    vecs.push_back(mkv(8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0));
    vecs.push_back(mkv(8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b1, 1'b1));
    vecs.push_back(mkv(8'hA0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0));
    vecs.push_back(mkv(8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0));
    vecs.push_back(mkv(8'hA2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0));
    vecs.push_back(mkv(8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA3A2A1A0, 4'hF, 1'b0, 1'b0));
    vecs.push_back(mkv(8'hA4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0));
    vecs.push_back(mkv(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000A5A4, 4'h3, 1'b1, 1'b0));
    vecs.push_back(mkv(8'hB0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0));
    vecs.push_back(mkv(8'hB1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0));
    vecs.push_back(mkv(8'hB2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00B2B1B0, 4'h5, 1'b1, 1'b0));
    vecs.push_back(mkv(8'hC0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h000000C0, 4'h1, 1'b1, 1'b0));

    repeat (3) step();
    rst = 1'b0;
    step();
    check("up_reset_out", 64'({up_m_valid, up_m_last, up_m_keep, up_m_data}), 64'(0));
    check("up_reset_rdy", 64'(up_s_ready), 64'(1));
    check("dn_reset_out", 64'({dn_m_valid, dn_m_last, dn_m_keep, dn_m_data}), 64'(0));
    check("dn_reset_rdy", 64'(dn_s_ready), 64'(1));

    // Table-driven upsize at full rate
    foreach (vecs[i]) begin
      if (vecs[i].emit) up_q.push_back(mke(vecs[i].exp_data, vecs[i].exp_keep,
                                           vecs[i].exp_last, vecs[i].exp_user));
      up_send(vecs[i].data, vecs[i].keep, vecs[i].last, vecs[i].user, n);
      check("up_accept_cycles", 64'(n), 64'(1));
      check("up_latency_valid", 64'(up_m_valid), 64'(vecs[i].emit));
    end
    step();

    // Upsize with output backpressure: next beat must stall until the word drains
    up_m_ready = 1'b0;
    up_send(8'hD0, 1'b1, 1'b0, 1'b0, n);
    up_send(8'hD1, 1'b1, 1'b0, 1'b0, n);
    up_send(8'hD2, 1'b1, 1'b0, 1'b0, n);
    up_q.push_back(mke(32'hD3D2D1D0, 4'hF, 1'b0, 1'b0));
    up_send(8'hD3, 1'b1, 1'b0, 1'b0, n);
    up_q.push_back(mke(32'h000000E0, 4'h1, 1'b1, 1'b0));
    up_s_valid = 1'b1; up_s_data = 8'hE0; up_s_keep = 1'b1; up_s_last = 1'b1;
    repeat (3) step();
    check("up_stall_rdy", 64'(up_s_ready), 64'(0));
    up_m_ready = 1'b1;
    n = 0;
    do begin step(); n++; end while (!up_fire && n < 50);
    check("up_stall_release", 64'(up_fire), 64'(1));
    up_s_valid = 1'b0;
    repeat (2) step();

    // Reset mid-packet discards the partial word
    up_send(8'h55, 1'b1, 1'b0, 1'b0, n);
    up_send(8'h66, 1'b1, 1'b0, 1'b0, n);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("up_rst_mid_valid", 64'(up_m_valid), 64'(0));
    check("up_rst_mid_rdy", 64'(up_s_ready), 64'(1));
    up_send(8'h01, 1'b1, 1'b0, 1'b0, n);
    up_send(8'h02, 1'b1, 1'b0, 1'b0, n);
    up_send(8'h03, 1'b1, 1'b0, 1'b0, n);
    up_q.push_back(mke(32'h04030201, 4'hF, 1'b1, 1'b0));
    up_send(8'h04, 1'b1, 1'b1, 1'b0, n);
    check("up_rst_next_word", 64'({up_m_valid, up_m_data}), 64'({1'b1, 32'h04030201}));
    step();

    // Downsize tlast word with partial keep: 0xDD dropped
    dn_q.push_back(mke(32'hAA, 4'h1, 1'b0, 1'b0));
    dn_q.push_back(mke(32'hBB, 4'h1, 1'b0, 1'b0));
    dn_q.push_back(mke(32'hCC, 4'h1, 1'b1, 1'b0));
    dn_send(32'hDDCCBBAA, 4'h7, 1'b1, 1'b0);
    check("dn_seg0_rdy", 64'({dn_m_valid, dn_s_ready}), 64'({1'b1, 1'b0}));
    step();
    check("dn_seg1_rdy", 64'(dn_s_ready), 64'(0));
    step();
    check("dn_seg2_rdy", 64'({dn_m_data, dn_m_last, dn_s_ready}), 64'({8'hCC, 1'b1, 1'b1}));
    step();
    check("dn_idle_after", 64'(dn_m_valid), 64'(0));

    // Back-to-back words with toggling downstream ready
    for (int b = 0; b < 8; b++) dn_q.push_back(mke(32'(b), 4'h1, 1'b0, 1'b0));
    dn_q.push_back(mke(32'h08, 4'h1, 1'b0, 1'b0));
    dn_q.push_back(mke(32'h09, 4'h1, 1'b1, 1'b0));
    dn_toggle = 1'b1;
    dn_send(32'h03020100, 4'hF, 1'b0, 1'b0);
    dn_send(32'h07060504, 4'hF, 1'b0, 1'b0);
    dn_send(32'h0B0A0908, 4'h3, 1'b1, 1'b0);
    repeat (20) step();
    dn_toggle = 1'b0;
    dn_m_ready = 1'b1;
    step();

    // All-zero-keep tlast word emits a single empty segment
    dn_q.push_back(mke(32'h78, 4'h0, 1'b1, 1'b0));
    dn_send(32'h12345678, 4'h0, 1'b1, 1'b0);
    check("dn_zero_keep_last", 64'({dn_m_valid, dn_m_keep, dn_m_last}), 64'({1'b1, 1'b0, 1'b1}));
    repeat (3) step();

`ifdef AXIS_WIDTH_CONV_TUSER_EN
    for (int b = 0; b < 4; b++) dn_q.push_back(mke(32'(8'h11 * (b + 1)), 4'h1, b == 3, 1'b1));
    dn_send(32'h44332211, 4'hF, 1'b1, 1'b1);
    repeat (6) step();
`endif

    repeat (5) step();
    check("up_queue_drained", 64'(up_q.size()), 64'(0));
    check("dn_queue_drained", 64'(dn_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
